// File: rtl/frame_sequencer.sv
// Frame sequencer: loads NCH input samples into data memory, starts the
// DSP core for RUN_CYCLES clocks, then drains NCH results to a stream.
// Ports:
//   clk, reset_n            : clock, async active-low reset
//   frame_tick              : frame strobe, acted on only in IDLE
//   in_valid/in_ready/in_data  : input sample handshake
//   wr_addr/wr_data/wr_en   : data-memory write port
//   rd_addr/rd_data         : data-memory read port (1-cycle latency)
//   dsp_start               : one-cycle DSP start pulse
//   out_valid/out_ready/out_data/out_chan : output sample handshake
//   busy, overrun           : status (overrun is sticky)
`timescale 1ns/1ps
module frame_sequencer #(
  parameter int DAW        = 10,
  parameter int DWW        = 36,
  parameter int NCH        = 8,
  parameter int IN_BASE    = 0,
  parameter int OUT_BASE   = 128,
  parameter int RUN_CYCLES = 520
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           frame_tick,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DWW-1:0] in_data,
  output logic [DAW-1:0] wr_addr,
  output logic [DWW-1:0] wr_data,
  output logic           wr_en,
  output logic [DAW-1:0] rd_addr,
  input  logic [DWW-1:0] rd_data,
  output logic           dsp_start,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DWW-1:0] out_data,
  output logic [5:0]     out_chan,
  output logic           busy,
  output logic           overrun
);

  localparam int CW = $clog2(NCH);
  localparam int RW = $clog2(RUN_CYCLES);
  localparam logic [CW-1:0]  LP_CH_LAST  = CW'(NCH - 1);
  localparam logic [RW-1:0]  LP_RUN_LAST = RW'(RUN_CYCLES - 1);
  localparam logic [DAW-1:0] LP_IN       = DAW'(IN_BASE);
  localparam logic [DAW-1:0] LP_OUT      = DAW'(OUT_BASE);

  if (NCH < 2 || NCH > 64) begin : g_bad_nch
    $error("frame_sequencer: NCH must be 2..64");
  end
  if (RUN_CYCLES < 4) begin : g_bad_run
    $error("frame_sequencer: RUN_CYCLES must be >= 4");
  end
  if (IN_BASE + NCH > (1 << DAW)) begin : g_bad_in
    $error("frame_sequencer: input block exceeds memory");
  end
  if (OUT_BASE + NCH > (1 << DAW)) begin : g_bad_out
    $error("frame_sequencer: output block exceeds memory");
  end

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_START,
    S_RUN,
    S_DRAIN_RD,
    S_DRAIN_OUT
  } state_t;

  state_t         r_state;
  state_t         w_state_nxt;
  logic [CW-1:0]  r_ch;
  logic [CW-1:0]  w_ch_nxt;
  logic [RW-1:0]  r_cnt;
  logic [RW-1:0]  w_cnt_nxt;
  logic [DAW-1:0] r_rd_addr;
  logic [DAW-1:0] w_rd_addr;
  logic [DWW-1:0] r_out_data;
  logic [5:0]     r_out_chan;
  logic           r_overrun;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
      r_ch    <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ch    <= w_ch_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ch_nxt    = r_ch;
    w_cnt_nxt   = r_cnt;
    unique case (r_state)
      S_IDLE: begin
        if (frame_tick) begin
          w_state_nxt = S_LOAD;
          w_ch_nxt    = '0;
        end
      end
      S_LOAD: begin
        if (in_valid) begin
          if (r_ch == LP_CH_LAST) begin
            w_state_nxt = S_START;
            w_ch_nxt    = '0;
          end else begin
            w_ch_nxt = r_ch + CW'(1);
          end
        end
      end
      S_START: begin
        w_state_nxt = S_RUN;
        w_cnt_nxt   = '0;
      end
      S_RUN: begin
        if (r_cnt == LP_RUN_LAST) begin
          w_state_nxt = S_DRAIN_RD;
          w_ch_nxt    = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + RW'(1);
        end
      end
      S_DRAIN_RD: begin
        w_state_nxt = S_DRAIN_OUT;
      end
      S_DRAIN_OUT: begin
        if (out_ready) begin
          if (r_ch == LP_CH_LAST) begin
            w_state_nxt = S_IDLE;
            w_ch_nxt    = '0;
          end else begin
            w_state_nxt = S_DRAIN_RD;
            w_ch_nxt    = r_ch + CW'(1);
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_ch_nxt    = '0;
        w_cnt_nxt   = '0;
      end
    endcase
    // Address leads DRAIN_RD by one cycle so a registered-read memory
    // has data ready at the edge that enters DRAIN_OUT; held otherwise.
    w_rd_addr = r_rd_addr;
    if (w_state_nxt == S_DRAIN_RD) begin
      w_rd_addr = LP_OUT + DAW'(w_ch_nxt);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rd_addr  <= '0;
      r_out_data <= '0;
      r_out_chan <= '0;
      r_overrun  <= 1'b0;
    end else begin
      r_rd_addr <= w_rd_addr;
      if (r_state == S_DRAIN_RD) begin
        r_out_data <= rd_data;
        r_out_chan <= 6'(r_ch);
      end
      if (frame_tick && (r_state != S_IDLE)) begin
        r_overrun <= 1'b1;
      end
    end
  end

  always_comb begin
    in_ready  = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    dsp_start = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      S_IDLE: busy = 1'b0;
      S_LOAD: begin
        in_ready = 1'b1;
        wr_en    = in_valid;
        wr_addr  = LP_IN + DAW'(r_ch);
        wr_data  = in_data;
      end
      S_START:     dsp_start = 1'b1;
      S_DRAIN_OUT: out_valid = 1'b1;
      default: ;
    endcase
  end

  assign rd_addr  = w_rd_addr;
  assign out_data = r_out_data;
  assign out_chan = r_out_chan;
  assign overrun  = r_overrun;

endmodule
